// File: rtl/regfile_multiport.sv
// -----------------------------------------------------------------------------
// regfile_multiport
//
// Parametrised register file with one synchronous write port and READ_PORTS
// independent registered read ports. It feeds the ALU operand and store-data
// paths, and replaces the old combinational 32:1 operand selectors.
//
// Each read port is a 2**ADDR_WIDTH:1 selector. The selected value is captured
// in a per-port output register, so rdata/rvalid come only from flops and
// there is no combinational input-to-output path.
//
// Parameters
//   DATA_WIDTH  bits per register
//   ADDR_WIDTH  address bits, depth = 2**ADDR_WIDTH
//   READ_PORTS  number of read ports (1..4)
//   ZERO_REG    1: entry 0 reads as zero and ignores writes
//   BYPASS      1: a read of the address written on the same edge returns
//               the new data; 0: it returns the pre-write contents
//
// Ports
//   i_clk     sole clock, rising edge
//   i_rst     synchronous active-high reset; clears memory, rdata and rvalid
//   i_we      write enable
//   i_waddr   write address
//   i_wdata   write data
//   i_re      per-port read enable, bit p belongs to port p
//   i_raddr   flattened read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   o_rdata   flattened registered read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   o_rvalid  per-port flag: rdata slice holds the previous cycle's read
//
// Read contract: there is no back-pressure. A port that samples i_re[p]=1 on
// an edge (outside reset) always completes; o_rvalid[p] is high for exactly
// the cycle after that edge, and o_rdata slice p holds the result until the
// next read on that port replaces it.
// -----------------------------------------------------------------------------
module regfile_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_we,
  input  logic [ADDR_WIDTH-1:0]            i_waddr,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  input  logic [READ_PORTS-1:0]            i_re,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] i_raddr,
  output logic [READ_PORTS*DATA_WIDTH-1:0] o_rdata,
  output logic [READ_PORTS-1:0]            o_rvalid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage array
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // A write to entry 0 is dropped when it is hardwired to zero. Bypass also
  // keys off this qualified enable, so a dropped write is never forwarded.
  logic w_wr_en;
  assign w_wr_en = i_we && !((ZERO_REG != 0) && (i_waddr == '0));

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read ports
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_is_zero;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_sel;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    assign w_addr    = i_raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_is_zero = (ZERO_REG != 0) && (w_addr == '0);
    assign w_hit     = (BYPASS != 0) && w_wr_en && (i_waddr == w_addr);

    // Priority: the hardwired zero beats bypass, bypass beats the array.
    always_comb begin
      w_sel = r_mem[w_addr];
      if (w_hit) begin
        w_sel = i_wdata;
      end
      if (w_is_zero) begin
        w_sel = '0;
      end
    end

    // Data holds while re is low; only rvalid drops.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_rdata  <= '0;
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= i_re[p];
        if (i_re[p]) begin
          r_rdata <= w_sel;
        end
      end
    end

    assign o_rdata[p*DATA_WIDTH +: DATA_WIDTH] = r_rdata;
    assign o_rvalid[p]                         = r_rvalid;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// -----------------------------------------------------------------------------
// tb_regfile_multiport
//
// Four copies of regfile_multiport share one stimulus stream, one per
// ZERO_REG/BYPASS combination:
//   cfg 0: ZERO_REG=1 BYPASS=1   cfg 1: ZERO_REG=1 BYPASS=0
//   cfg 2: ZERO_REG=0 BYPASS=1   cfg 3: ZERO_REG=0 BYPASS=0
// A behavioural model (plain array plus expected outputs) tracks all four and
// is compared every cycle; directed steps also check hand-computed literals.
// -----------------------------------------------------------------------------
module tb_regfile_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RP = 2;
  localparam int NC = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic               we;
  logic [AW-1:0]      waddr;
  logic [DW-1:0]      wdata;
  logic [RP-1:0]      re;
  logic [RP*AW-1:0]   raddr;

  logic [NC-1:0][RP*DW-1:0] dut_rdata;
  logic [NC-1:0][RP-1:0]    dut_rvalid;

  for (genvar c = 0; c < NC; c++) begin : g_dut
    regfile_multiport #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .READ_PORTS(RP),
      .ZERO_REG  ((c < 2) ? 1 : 0),
      .BYPASS    ((c % 2 == 0) ? 1 : 0)
    ) u_dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_we    (we),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .i_re    (re),
      .i_raddr (raddr),
      .o_rdata (dut_rdata[c]),
      .o_rvalid(dut_rvalid[c])
    );
  end

  // ---------------------------------------------------------------- model
  logic [DW-1:0] m_mem    [NC][32];
  logic [DW-1:0] exp_rdata[NC][RP];
  logic          exp_rvalid[NC][RP];

  function automatic bit cfg_zr(int c);
    return c < 2;
  endfunction

  function automatic bit cfg_bp(int c);
    return (c % 2) == 0;
  endfunction

  // Value a read of address a sees on this edge, from the rules:
  // zero register wins, then a bypassed live write, else stored contents.
  function automatic logic [DW-1:0] model_read(int c, int a);
    if (cfg_zr(c) && a == 0) return '0;
    if (cfg_bp(c) && we && int'(waddr) == a) return wdata;
    return m_mem[c][a];
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (rst) begin
        for (int a = 0; a < 32; a++) m_mem[c][a] = '0;
        for (int p = 0; p < RP; p++) begin
          exp_rdata[c][p]  = '0;
          exp_rvalid[c][p] = 1'b0;
        end
      end else begin
        for (int p = 0; p < RP; p++) begin
          exp_rvalid[c][p] = re[p];
          if (re[p]) exp_rdata[c][p] = model_read(c, int'(raddr[p*AW +: AW]));
        end
        if (we && !(cfg_zr(c) && waddr == '0)) m_mem[c][waddr] = wdata;
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NC; c++) begin
        for (int p = 0; p < RP; p++) begin
          n_cmp++;
          if (dut_rvalid[c][p] !== exp_rvalid[c][p]) begin
            n_fail++;
            $display("FAIL rvalid cfg%0d port%0d t=%0t: got %b expected %b",
                     c, p, $time, dut_rvalid[c][p], exp_rvalid[c][p]);
          end
          n_cmp++;
          if (dut_rdata[c][p*DW +: DW] !== exp_rdata[c][p]) begin
            n_fail++;
            $display("FAIL rdata cfg%0d port%0d t=%0t: got %h expected %h",
                     c, p, $time, dut_rdata[c][p*DW +: DW], exp_rdata[c][p]);
          end
        end
      end
    end
  end

  // Hand-computed literal expectation on one port of one configuration.
  task automatic check_lit(string name, int c, int p, logic v, logic [DW-1:0] d);
    n_cmp++;
    if (dut_rvalid[c][p] !== v || dut_rdata[c][p*DW +: DW] !== d) begin
      n_fail++;
      $display("FAIL %s cfg%0d port%0d: got valid=%b data=%h expected valid=%b data=%h",
               name, c, p, dut_rvalid[c][p], dut_rdata[c][p*DW +: DW], v, d);
    end
  endtask

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic w, int wa, logic [DW-1:0] wd, logic [RP-1:0] r, int a0, int a1);
    we    = w;
    waddr = AW'(wa);
    wdata = wd;
    re    = r;
    raddr = {AW'(a1), AW'(a0)};
  endtask

  task automatic idle();
    drive(1'b0, 0, '0, 2'b00, 0, 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1;
    // A write and reads during reset must be lost.
    drive(1'b1, 9, 32'h9999_9999, 2'b11, 9, 9);
    tick();
    chk_en = 1'b1;
    tick();
    for (int c = 0; c < NC; c++) begin
      check_lit("reset_p0", c, 0, 1'b0, 32'h0);
      check_lit("reset_p1", c, 1, 1'b0, 32'h0);
    end
    rst = 1'b0;

    // Reset then read every address on both ports.
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 0, '0, 2'b11, a, a);
      tick();
      check_lit("rst_read_p0", 3, 0, 1'b1, 32'h0);
      check_lit("rst_read_p1", 3, 1, 1'b1, 32'h0);
    end
    idle();
    tick();
    check_lit("valid_drop", 0, 0, 1'b0, 32'h0);

    // Write/read-back, addresses 1..31.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, i, 32'hA5A5_0000 + DW'(i), 2'b00, 0, 0);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 0, '0, 2'b11, i, 31 - i);
      tick();
      check_lit("readback_p0", 0, 0, 1'b1, (i == 0) ? 32'h0 : 32'hA5A5_0000 + DW'(i));
      check_lit("readback_p1", 1, 1, 1'b1, (i == 31) ? 32'h0 : 32'hA5A5_0000 + DW'(31 - i));
    end

    // Collision on address 7.
    drive(1'b1, 7, 32'h1111_1111, 2'b00, 0, 0);
    tick();
    drive(1'b1, 7, 32'h2222_2222, 2'b11, 7, 7);
    tick();
    check_lit("coll_bp1_p0", 0, 0, 1'b1, 32'h2222_2222);
    check_lit("coll_bp1_p1", 0, 1, 1'b1, 32'h2222_2222);
    check_lit("coll_bp0_p0", 1, 0, 1'b1, 32'h1111_1111);
    check_lit("coll_bp0_p1", 1, 1, 1'b1, 32'h1111_1111);
    drive(1'b0, 0, '0, 2'b11, 7, 7);
    tick();
    check_lit("coll_after_bp0", 1, 0, 1'b1, 32'h2222_2222);
    check_lit("coll_after_bp1", 0, 1, 1'b1, 32'h2222_2222);

    // Zero register: write 0xDEADBEEF to 0 with a simultaneous read of 0.
    drive(1'b1, 0, 32'hDEAD_BEEF, 2'b11, 0, 0);
    tick();
    check_lit("zero_zr1", 0, 0, 1'b1, 32'h0);
    check_lit("zero_zr0_bp1", 2, 1, 1'b1, 32'hDEAD_BEEF);
    check_lit("zero_zr0_bp0", 3, 0, 1'b1, 32'h0);
    drive(1'b0, 0, '0, 2'b11, 0, 0);
    tick();
    check_lit("zero_next_zr1", 1, 1, 1'b1, 32'h0);
    check_lit("zero_next_zr0", 3, 1, 1'b1, 32'hDEAD_BEEF);

    // Hold: read 3 (=0x33), then drop re for 3 cycles while writing 0x44.
    drive(1'b1, 3, 32'h33, 2'b00, 0, 0);
    tick();
    drive(1'b0, 0, '0, 2'b01, 3, 0);
    tick();
    check_lit("hold_read", 0, 0, 1'b1, 32'h33);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3, 32'h44, 2'b00, 3, 3);
      tick();
      for (int c = 0; c < NC; c++) check_lit("hold_keep", c, 0, 1'b0, 32'h33);
    end
    drive(1'b0, 0, '0, 2'b10, 0, 3);
    tick();
    check_lit("hold_new", 2, 1, 1'b1, 32'h44);

    // Reset mid-stream with a write and reads in the same cycle.
    rst = 1'b1;
    drive(1'b1, 5, 32'h55, 2'b11, 5, 5);
    tick();
    check_lit("midrst_p0", 0, 0, 1'b0, 32'h0);
    check_lit("midrst_p1", 3, 1, 1'b0, 32'h0);
    rst = 1'b0;
    drive(1'b0, 0, '0, 2'b11, 5, 3);
    tick();
    check_lit("after_rst_5", 0, 0, 1'b1, 32'h0);
    check_lit("after_rst_3", 2, 1, 1'b1, 32'h0);

    idle();
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
